// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared memory-support defaults and helpers
package mem_responder_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_CNT_W  = 16;
  localparam int MEM_DEPTH  = 16;

  // Arbiter defaults shared by the memory-support blocks
  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_ID_W    = 2;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_sat_counter.sv
// rtl/mem_sat_counter.sv - saturating up-counter, holds at all-ones
module mem_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - register-based memory with 1-cycle read, access counters, sticky range error
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_TYPE = MEM_ADDR_W,
  parameter int DATA_TYPE = MEM_DATA_W,
  parameter int DEPTH     = MEM_DEPTH,
  parameter int CNT_WIDTH = MEM_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_enable,
  input  logic [ADDR_TYPE-1:0] read_address,
  output logic [DATA_TYPE-1:0] data_from_memory,
  output logic                 read_valid,
  input  logic                 write_enable,
  input  logic                 enable,
  input  logic [ADDR_TYPE-1:0] write_address,
  input  logic [DATA_TYPE-1:0] data_to_memory,
  output logic [CNT_WIDTH-1:0] read_count,
  output logic [CNT_WIDTH-1:0] write_count,
  output logic                 addr_error
);

  localparam int                   IDX_W   = idx_width(DEPTH);
  localparam logic [ADDR_TYPE-1:0] DEPTH_A = ADDR_TYPE'(DEPTH);

  logic [DATA_TYPE-1:0] r_mem [DEPTH];
  logic [DATA_TYPE-1:0] r_rdata;
  logic                 r_rvalid;
  logic                 r_addr_err;

  logic             w_rd_in, w_wr_in;
  logic             w_rd_ok, w_wr_ok;
  logic             w_rd_oob, w_wr_oob;
  logic [IDX_W-1:0] w_rd_idx, w_wr_idx;

  // Full-width compare so high address bits can never alias into range
  assign w_rd_in  = (read_address < DEPTH_A);
  assign w_wr_in  = (write_address < DEPTH_A);
  assign w_rd_ok  = read_enable && w_rd_in;
  assign w_wr_ok  = write_enable && enable && w_wr_in;
  assign w_rd_oob = read_enable && !w_rd_in;
  assign w_wr_oob = write_enable && enable && !w_wr_in;
  assign w_rd_idx = read_address[IDX_W-1:0];
  assign w_wr_idx = write_address[IDX_W-1:0];

  // Read samples r_mem before the same-edge write lands, giving read-first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[w_wr_idx] <= data_to_memory;
      end
      r_rvalid <= read_enable;
      if (read_enable) begin
        r_rdata <= w_rd_in ? r_mem[w_rd_idx] : '0;
      end
      if (w_rd_oob || w_wr_oob) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  mem_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_read_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_rd_ok),
    .count (read_count)
  );

  mem_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_write_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_wr_ok),
    .count (write_count)
  );

  assign data_from_memory = r_rdata;
  assign read_valid       = r_rvalid;
  assign addr_error       = r_addr_err;

endmodule
